mem_port_arbiter: RTL and testbench

//  Shares one single-port memory bus between the core's three MMU-side requesters:

---
 rtl/mem_port_arbiter_if.sv | 42 ++++
 rtl/mem_port_arbiter.sv | 119 +++++++++++
 tb/tb_mem_port_arbiter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the core-side request/response signals and the single-port memory bus
// seen by mem_port_arbiter.
interface mem_port_arbiter_if;
  // Handshake: a requester holds its enable, address and data while mem_wait=1; an
  // access completes in the cycle where mem_req and mem_ack are both 1, and mem_ack may
  // be a combinational function of mem_req. *_rvalid are single-cycle pulses.
  logic        inst_rden;
  logic [31:0] inst_riaddr;
  logic [31:0] inst_roaddr;
  logic        inst_rvalid;
  logic [31:0] inst_rdata;
  logic        data_rden;
  logic [31:0] data_riaddr;
  logic [31:0] data_roaddr;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        data_wren;
  logic [31:0] data_waddr;
  logic [31:0] data_wdata;
  logic        mem_wait;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_err;

  modport master (
    output inst_rden, inst_riaddr, data_rden, data_riaddr,
           data_wren, data_waddr, data_wdata, mem_ack, mem_rdata,
    input  inst_roaddr, inst_rvalid, inst_rdata, data_roaddr, data_rvalid, data_rdata,
           mem_wait, mem_req, mem_we, mem_addr, mem_wdata, mem_err
  );

  modport slave (
    input  inst_rden, inst_riaddr, data_rden, data_riaddr,
           data_wren, data_waddr, data_wdata, mem_ack, mem_rdata,
    output inst_roaddr, inst_rvalid, inst_rdata, data_roaddr, data_rvalid, data_rdata,
           mem_wait, mem_req, mem_we, mem_addr, mem_wdata, mem_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises write > data read > fetch onto one memory port, stalls the core until the
// request set is served and returns tagged read data one cycle after completion.
module mem_port_arbiter #(
  parameter int ACK_TIMEOUT = 256
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  mem_port_arbiter_if.slave   bus,
  output logic [2:0]          dbg_done_o
);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(ACK_TIMEOUT);

  logic          d_w_q, d_r_q, d_i_q, d_w_d, d_r_d, d_i_d;
  logic          pend_w, pend_r, pend_i, any_pend;
  logic          g_w, g_r, g_i, single, ack, last;
  logic          inst_rvalid_q, inst_rvalid_d, data_rvalid_q, data_rvalid_d;
  logic [31:0]   inst_rdata_q, inst_rdata_d, inst_roaddr_q, inst_roaddr_d;
  logic [31:0]   data_rdata_q, data_rdata_d, data_roaddr_q, data_roaddr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  // Gating with rst_ni keeps every combinational bus output at 0 while reset is held.
  always_comb begin
    pend_w   = rst_ni & bus.data_wren & ~d_w_q;
    pend_r   = rst_ni & bus.data_rden & ~d_r_q;
    pend_i   = rst_ni & bus.inst_rden & ~d_i_q;
    any_pend = pend_w | pend_r | pend_i;
    g_w      = pend_w;
    g_r      = pend_r & ~pend_w;
    g_i      = pend_i & ~pend_w & ~pend_r;
    single   = (g_w & ~pend_r & ~pend_i) | (g_r & ~pend_i) | g_i;
    ack      = bus.mem_ack & any_pend;
    last     = ack & single;
  end

  assign bus.mem_req   = any_pend;
  assign bus.mem_we    = g_w;
  assign bus.mem_addr  = g_w ? bus.data_waddr :
                         g_r ? bus.data_riaddr :
                         g_i ? bus.inst_riaddr : 32'h0;
  assign bus.mem_wdata = g_w ? bus.data_wdata : 32'h0;
  assign bus.mem_wait  = any_pend & ~last;

  always_comb begin
    d_w_d         = d_w_q;
    d_r_d         = d_r_q;
    d_i_d         = d_i_q;
    inst_rdata_d  = inst_rdata_q;
    inst_roaddr_d = inst_roaddr_q;
    data_rdata_d  = data_rdata_q;
    data_roaddr_d = data_roaddr_q;
    cnt_d         = cnt_q;
    err_d         = err_q;
    // A read was served in this set if it is acked now or was marked done earlier.
    inst_rvalid_d = last & (d_i_q | g_i);
    data_rvalid_d = last & (d_r_q | g_r);
    if (last) begin
      d_w_d = 1'b0;
      d_r_d = 1'b0;
      d_i_d = 1'b0;
    end else if (ack) begin
      d_w_d = d_w_q | g_w;
      d_r_d = d_r_q | g_r;
      d_i_d = d_i_q | g_i;
    end
    if (ack & g_r) begin
      data_rdata_d  = bus.mem_rdata;
      data_roaddr_d = bus.data_riaddr;
    end
    if (ack & g_i) begin
      inst_rdata_d  = bus.mem_rdata;
      inst_roaddr_d = bus.inst_riaddr;
    end
    if (any_pend & ~bus.mem_ack) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_MAX - 1'b1) err_d = 1'b1;
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      d_w_q         <= 1'b0;
      d_r_q         <= 1'b0;
      d_i_q         <= 1'b0;
      inst_rvalid_q <= 1'b0;
      data_rvalid_q <= 1'b0;
      inst_rdata_q  <= 32'h0;
      inst_roaddr_q <= 32'h0;
      data_rdata_q  <= 32'h0;
      data_roaddr_q <= 32'h0;
      cnt_q         <= '0;
      err_q         <= 1'b0;
    end else begin
      d_w_q         <= d_w_d;
      d_r_q         <= d_r_d;
      d_i_q         <= d_i_d;
      inst_rvalid_q <= inst_rvalid_d;
      data_rvalid_q <= data_rvalid_d;
      inst_rdata_q  <= inst_rdata_d;
      inst_roaddr_q <= inst_roaddr_d;
      data_rdata_q  <= data_rdata_d;
      data_roaddr_q <= data_roaddr_d;
      cnt_q         <= cnt_d;
      err_q         <= err_d;
    end
  end

  assign bus.inst_rvalid = inst_rvalid_q;
  assign bus.inst_rdata  = inst_rdata_q;
  assign bus.inst_roaddr = inst_roaddr_q;
  assign bus.data_rvalid = data_rvalid_q;
  assign bus.data_rdata  = data_rdata_q;
  assign bus.data_roaddr = data_roaddr_q;
  assign bus.mem_err     = err_q;
  assign dbg_done_o      = {d_w_q, d_r_q, d_i_q};
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a transaction-level model:
// each request set expands to an ordered access list with per-access ack delays.
module tb_mem_port_arbiter;
  localparam int ACK_TO = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus();
  logic [2:0]  dbg_done;
  logic        ack_en;
  logic [31:0] resp_mem  [0:255];
  logic [31:0] model_mem [0:255];

  // Memory responder: ack is combinational from mem_req, delayed by the driver via ack_en.
  assign bus.mem_ack   = bus.mem_req & ack_en;
  assign bus.mem_rdata = resp_mem[bus.mem_addr[9:2]];

  mem_port_arbiter #(.ACK_TIMEOUT(ACK_TO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus), .dbg_done_o(dbg_done)
  );

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [64:0] exp_q[$];
  bit          exp_iv, exp_dv, exp_err;
  logic [31:0] last_itag, last_idata, last_dtag, last_ddata;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    check_val(tag, {31'b0, obs}, {31'b0, exp});
  endtask

  task automatic check_resp();
    check_bit("inst_rvalid", bus.inst_rvalid, exp_iv);
    check_val("inst_roaddr", bus.inst_roaddr, last_itag);
    check_val("inst_rdata",  bus.inst_rdata,  last_idata);
    check_bit("data_rvalid", bus.data_rvalid, exp_dv);
    check_val("data_roaddr", bus.data_roaddr, last_dtag);
    check_val("data_rdata",  bus.data_rdata,  last_ddata);
    check_val("done_flags",  {29'b0, dbg_done}, 32'h0);
    exp_iv = 1'b0;
    exp_dv = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_bit({tag, "_req"},  bus.mem_req, 1'b0);
    check_bit({tag, "_wait"}, bus.mem_wait, 1'b0);
    check_bit({tag, "_we"},   bus.mem_we, 1'b0);
    check_val({tag, "_addr"}, bus.mem_addr, 32'h0);
    check_val({tag, "_wdata"}, bus.mem_wdata, 32'h0);
    check_bit({tag, "_err"},  bus.mem_err, 1'b0);
    check_bit({tag, "_irv"},  bus.inst_rvalid, 1'b0);
    check_bit({tag, "_drv"},  bus.data_rvalid, 1'b0);
    check_val({tag, "_irdata"}, bus.inst_rdata, 32'h0);
    check_val({tag, "_iroaddr"}, bus.inst_roaddr, 32'h0);
    check_val({tag, "_drdata"}, bus.data_rdata, 32'h0);
    check_val({tag, "_droaddr"}, bus.data_roaddr, 32'h0);
    check_val({tag, "_done"}, {29'b0, dbg_done}, 32'h0);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit ew, input bit er, input bit ei,
                       input logic [31:0] wa, input logic [31:0] wd,
                       input logic [31:0] ra, input logic [31:0] ia);
    bus.data_wren   = ew;
    bus.data_waddr  = wa;
    bus.data_wdata  = wd;
    bus.data_rden   = er;
    bus.data_riaddr = ra;
    bus.inst_rden   = ei;
    bus.inst_riaddr = ia;
  endtask

  // Called at posedge+1; leaves time at posedge+1 of the cycle after the set completes.
  task automatic run_set(input bit ew, input bit er, input bit ei,
                         input logic [31:0] wa, input logic [31:0] wd,
                         input logic [31:0] ra, input logic [31:0] ia,
                         input int d0, input int d1, input int d2);
    int          dl[3];
    int          n;
    bit          first;
    logic [64:0] e;
    logic        obs_we;
    logic [31:0] obs_addr, obs_wd;
    dl = '{d0, d1, d2};
    drive(ew, er, ei, wa, wd, ra, ia);
    n = 0;
    if (ew) begin exp_q.push_back({1'b1, wa, wd});    n++; end
    if (er) begin exp_q.push_back({1'b0, ra, 32'h0}); n++; end
    if (ei) begin exp_q.push_back({1'b0, ia, 32'h0}); n++; end
    if (n == 0) begin
      ack_en = 1'b0;
      @(negedge clk);
      check_resp();
      check_bit("idle_req",  bus.mem_req, 1'b0);
      check_bit("idle_wait", bus.mem_wait, 1'b0);
      check_bit("mem_err",   bus.mem_err, exp_err);
      @(posedge clk);
      #1;
      return;
    end
    first = 1'b1;
    for (int k = 0; k < n; k++) begin
      e = exp_q.pop_front();
      for (int j = 0; j <= dl[k]; j++) begin
        ack_en = (j == dl[k]);
        if (j >= ACK_TO) exp_err = 1'b1;
        @(negedge clk);
        if (first) check_resp();
        first = 1'b0;
        check_bit("mem_req",  bus.mem_req, 1'b1);
        check_bit("mem_we",   bus.mem_we, e[64]);
        check_val("mem_addr", bus.mem_addr, e[63:32]);
        if (e[64]) check_val("mem_wdata", bus.mem_wdata, e[31:0]);
        check_bit("mem_wait", bus.mem_wait, !((j == dl[k]) && (k == n - 1)));
        check_bit("mem_err",  bus.mem_err, exp_err);
        obs_we   = bus.mem_we;
        obs_addr = bus.mem_addr;
        obs_wd   = bus.mem_wdata;
        @(posedge clk);
        if ((j == dl[k]) && obs_we) resp_mem[obs_addr[9:2]] = obs_wd;
        #1;
      end
    end
    // Reads in a set see the set's write, which is always served first.
    if (ew) model_mem[wa[9:2]] = wd;
    if (er) begin exp_dv = 1'b1; last_dtag = ra; last_ddata = model_mem[ra[9:2]]; end
    if (ei) begin exp_iv = 1'b1; last_itag = ia; last_idata = model_mem[ia[9:2]]; end
  endtask

  task automatic idle_cycle();
    run_set(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] base;
    logic [31:0] idx;
    base = $urandom() & 32'hFFFF_FC00;
    idx  = $urandom_range(0, 7);
    return base | (idx << 2);
  endfunction

  function automatic int rand_delay();
    if ($urandom_range(0, 1) == 1) return 0;
    return $urandom_range(1, 3);
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    bit          ew, er, ei;
    logic [31:0] wa, wd, ra, ia;
    for (int i = 0; i < 256; i++) begin
      resp_mem[i]  = $urandom();
      model_mem[i] = resp_mem[i];
    end
    exp_iv = 0; exp_dv = 0; exp_err = 0;
    last_itag = 0; last_idata = 0; last_dtag = 0; last_ddata = 0;
    ack_en = 1'b0;
    drive(0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
    #12;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Lone fetch with zero-wait memory.
    resp_mem[32'h100 >> 2]  = 32'h0000_0013;
    model_mem[32'h100 >> 2] = 32'h0000_0013;
    run_set(0, 0, 1, 32'h0, 32'h0, 32'h0, 32'h100, 0, 0, 0);
    @(negedge clk);
    check_val("t1_rdata", bus.inst_rdata, 32'h13);
    @(posedge clk); #1;
    idle_cycle();

    // Full three-request set, zero wait.
    run_set(1, 1, 1, 32'h20, 32'hDEAD_BEEF, 32'h40, 32'h104, 0, 0, 0);
    idle_cycle();
    // Data read with delayed ack.
    run_set(0, 1, 0, 32'h0, 32'h0, 32'h80, 32'h0, 3, 0, 0);
    idle_cycle();
    // Back-to-back fetches.
    run_set(0, 0, 1, 32'h0, 32'h0, 32'h0, 32'h200, 0, 0, 0);
    run_set(0, 0, 1, 32'h0, 32'h0, 32'h0, 32'h204, 0, 0, 0);
    idle_cycle();
    // Write then read of the same address within one set.
    run_set(1, 1, 0, 32'h30, 32'h1234_5678, 32'h30, 32'h0, 1, 2, 0);
    idle_cycle();

    // Reset while the second of three requests is waiting.
    drive(1, 1, 1, 32'h60, 32'hCAFE_F00D, 32'h64, 32'h108);
    ack_en = 1'b1;
    @(negedge clk);
    check_resp();
    check_val("rst_t_addr0", bus.mem_addr, 32'h60);
    @(posedge clk);
    resp_mem[bus.mem_addr[9:2]] = bus.mem_wdata;
    #1;
    ack_en = 1'b0;
    @(negedge clk);
    check_val("rst_t_addr1", bus.mem_addr, 32'h64);
    check_bit("rst_t_wait", bus.mem_wait, 1'b1);
    check_val("rst_t_done", {29'b0, dbg_done}, 32'h4);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    model_mem[32'h60 >> 2] = 32'hCAFE_F00D;
    last_itag = 0; last_idata = 0; last_dtag = 0; last_ddata = 0;
    exp_iv = 0; exp_dv = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_set(1, 1, 1, 32'h60, 32'hCAFE_F00D, 32'h64, 32'h108, 0, 0, 0);

    // Randomized sets, some back-to-back, some separated by idle cycles.
    for (int it = 0; it < 120; it++) begin
      ew = ($urandom_range(0, 1) == 1);
      er = ($urandom_range(0, 1) == 1);
      ei = ($urandom_range(0, 1) == 1);
      wa = rand_addr();
      wd = $urandom();
      ra = ($urandom_range(0, 3) == 0) ? wa : rand_addr();
      ia = rand_addr();
      run_set(ew, er, ei, wa, wd, ra, ia, rand_delay(), rand_delay(), rand_delay());
      if ($urandom_range(0, 4) == 0) idle_cycle();
    end
    idle_cycle();

    // Ack withheld past the timeout: sticky error, transfer still completes.
    run_set(0, 1, 0, 32'h0, 32'h0, 32'h84, 32'h0, 6, 0, 0);
    idle_cycle();
    @(negedge clk);
    check_bit("err_sticky", bus.mem_err, 1'b1);
    rst_n = 1'b0;
    #1;
    check_bit("err_reset", bus.mem_err, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
